// File: rtl/hack_cpu_pkg.sv
// Shared types and field positions for the multi-cycle Hack CPU.
package hack_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR,
        HALTED
    } state_t;

    // Instruction word field positions
    localparam int IR_TYPE    = 15;
    localparam int IR_ABIT    = 12;
    localparam int IR_CMP_HI  = 11;
    localparam int IR_CMP_LO  = 6;
    localparam int IR_DEST_A  = 5;
    localparam int IR_DEST_D  = 4;
    localparam int IR_DEST_M  = 3;
    localparam int IR_JMP_HI  = 2;
    localparam int IR_JMP_LO  = 0;

    // Jump codes (j1 j2 j3)
    localparam logic [2:0] J_NULL = 3'd0;
    localparam logic [2:0] J_GT   = 3'd1;
    localparam logic [2:0] J_EQ   = 3'd2;
    localparam logic [2:0] J_GE   = 3'd3;
    localparam logic [2:0] J_LT   = 3'd4;
    localparam logic [2:0] J_NE   = 3'd5;
    localparam logic [2:0] J_LE   = 3'd6;
    localparam logic [2:0] J_MP   = 3'd7;

    // Jump condition from the ALU flags of the result being written back
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        logic t;
        case (j)
            J_NULL:  t = 1'b0;
            J_GT:    t = ~ng & ~zr;
            J_EQ:    t = zr;
            J_GE:    t = ~ng;
            J_LT:    t = ng;
            J_NE:    t = ~zr;
            J_LE:    t = ng | zr;
            J_MP:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Standard Hack ALU: pre-zero/negate each operand, add or AND, optional output negate.
module hack_alu #(
    parameter int D_WIDTH = 16
) (
    input  logic [D_WIDTH-1:0] x,
    input  logic [D_WIDTH-1:0] y,
    input  logic               zx,
    input  logic               nx,
    input  logic               zy,
    input  logic               ny,
    input  logic               f,
    input  logic               no,
    output logic [D_WIDTH-1:0] out,
    output logic               zr,
    output logic               ng
);

    logic [D_WIDTH-1:0] xa, ya, fo;

    // Purely combinational compute of result and flags
    always_comb begin
        xa  = zx ? '0 : x;
        if (nx) xa = ~xa;
        ya  = zy ? '0 : y;
        if (ny) ya = ~ya;
        fo  = f ? (xa + ya) : (xa & ya);
        out = no ? ~fo : fo;
        zr  = (out == '0);
        ng  = out[D_WIDTH-1];
    end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack handshakes to ROM and RAM and self-loop halt detection.
module hack_cpu_mc
    import hack_cpu_pkg::*;
#(
    parameter int WORD_WIDTH        = 16,
    parameter int ROM_ADDRESS_WIDTH = 15,  // must not exceed WORD_WIDTH (jump target is A)
    parameter int RAM_ADDRESS_WIDTH = 15,
    parameter int HALT_DETECT       = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         rom_req,
    output logic [ROM_ADDRESS_WIDTH-1:0] rom_addr,
    input  logic                         rom_ack,
    input  logic [WORD_WIDTH-1:0]        rom_data,
    output logic                         ram_req,
    output logic                         ram_we,
    output logic [RAM_ADDRESS_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0]        ram_wdata,
    input  logic                         ram_ack,
    input  logic [WORD_WIDTH-1:0]        ram_rdata,
    output logic [ROM_ADDRESS_WIDTH-1:0] pc,
    output logic                         halted
);

    localparam logic [ROM_ADDRESS_WIDTH-1:0] PC_ONE = ROM_ADDRESS_WIDTH'(1);

    state_t                       state, state_nxt;
    logic [ROM_ADDRESS_WIDTH-1:0] pc_q, pc_pend, pc_next, jmp_tgt;
    logic [WORD_WIDTH-1:0]        a_q, d_q, ir_q, m_lat, wdata_q;
    logic [WORD_WIDTH-1:0]        alu_y, alu_r, jmp_src;
    logic [RAM_ADDRESS_WIDTH-1:0] addr_q;
    logic                         alu_zr, alu_ng, taken, halt_now;
    logic                         halt_pend, prev_a;
    logic                         rom_req_q, ram_req_q, ram_we_q, halted_q;
    logic [5:0]                   cmp;

    assign cmp = ir_q[IR_CMP_HI:IR_CMP_LO];

    hack_alu #(.D_WIDTH(WORD_WIDTH)) u_alu (
        .x  (d_q),
        .y  (alu_y),
        .zx (cmp[5]),
        .nx (cmp[4]),
        .zy (cmp[3]),
        .ny (cmp[2]),
        .f  (cmp[1]),
        .no (cmp[0]),
        .out(alu_r),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    // Operand select, jump resolution and halt detection for the EXEC cycle
    always_comb begin
        alu_y    = ir_q[IR_ABIT] ? m_lat : a_q;
        // Target is the A value after this instruction, so "A=M;JMP" works
        jmp_src  = ir_q[IR_DEST_A] ? alu_r : a_q;
        jmp_tgt  = jmp_src[ROM_ADDRESS_WIDTH-1:0];
        taken    = jump_taken(ir_q[IR_JMP_HI:IR_JMP_LO], alu_zr, alu_ng);
        pc_next  = taken ? jmp_tgt : (pc_q + PC_ONE);
        // "(END) @END; 0;JMP": taken jump back onto the preceding A-instruction
        halt_now = (HALT_DETECT != 0) && taken && prev_a && (jmp_tgt == (pc_q - PC_ONE));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH:   if (rom_req_q && rom_ack) state_nxt = DECODE;
            DECODE:  if (!ir_q[IR_TYPE])      state_nxt = FETCH;
                     else if (ir_q[IR_ABIT])  state_nxt = MEM_RD;
                     else                     state_nxt = EXEC;
            MEM_RD:  if (ram_req_q && ram_ack) state_nxt = EXEC;
            EXEC:    if (ir_q[IR_DEST_M])     state_nxt = MEM_WR;
                     else if (halt_now)       state_nxt = HALTED;
                     else                     state_nxt = FETCH;
            MEM_WR:  if (ram_req_q && ram_ack) state_nxt = halt_pend ? HALTED : FETCH;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    // State register and registered handshake outputs (drop at once on reset)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            rom_req_q <= 1'b0;
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_req_q <= (state_nxt == FETCH);
            ram_req_q <= (state_nxt == MEM_RD) || (state_nxt == MEM_WR);
            ram_we_q  <= (state_nxt == MEM_WR);
            halted_q  <= (state_nxt == HALTED);
        end
    end

    // Architectural registers, latched operands and deferred PC update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            pc_pend   <= '0;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            m_lat     <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            halt_pend <= 1'b0;
            prev_a    <= 1'b0;
        end else begin
            unique case (state)
                FETCH: if (rom_req_q && rom_ack) ir_q <= rom_data;
                DECODE: begin
                    addr_q <= a_q[RAM_ADDRESS_WIDTH-1:0];
                    if (!ir_q[IR_TYPE]) begin
                        a_q    <= ir_q;
                        pc_q   <= pc_q + PC_ONE;
                        prev_a <= 1'b1;
                    end
                end
                MEM_RD: if (ram_req_q && ram_ack) m_lat <= ram_rdata;
                EXEC: begin
                    // M write targets the A value from before this instruction
                    addr_q  <= a_q[RAM_ADDRESS_WIDTH-1:0];
                    wdata_q <= alu_r;
                    prev_a  <= 1'b0;
                    if (ir_q[IR_DEST_A]) a_q <= alu_r;
                    if (ir_q[IR_DEST_D]) d_q <= alu_r;
                    if (ir_q[IR_DEST_M]) begin
                        pc_pend   <= pc_next;
                        halt_pend <= halt_now;
                    end else begin
                        pc_q <= pc_next;
                    end
                end
                MEM_WR: if (ram_req_q && ram_ack) pc_q <= pc_pend;
                default: ;
            endcase
        end
    end

    assign rom_req   = rom_req_q;
    assign rom_addr  = pc_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: memory models with programmable wait states.
module tb_hack_cpu_mc;

    localparam logic [5:0] C_ZERO = 6'b101010;
    localparam logic [5:0] C_ONE  = 6'b111111;
    localparam logic [5:0] C_NEG1 = 6'b111010;
    localparam logic [5:0] C_D    = 6'b001100;
    localparam logic [5:0] C_A    = 6'b110000;
    localparam logic [5:0] C_AP1  = 6'b110111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0, reset_n2 = 1'b0;
    logic        rom_req, rom_ack, ram_req, ram_we, ram_ack, halted;
    logic [14:0] rom_addr, ram_addr, pc;
    logic [15:0] rom_data, ram_wdata, ram_rdata;

    logic        u1_rom_req, u1_rom_ack, u1_ram_req, u1_ram_we, u1_ram_ack, u1_halted;
    logic [14:0] u1_rom_addr, u1_ram_addr, u1_pc;
    logic [15:0] u1_rom_data, u1_ram_wdata, u1_ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] rom     [0:63];
    logic [15:0] ram     [0:63];
    logic [15:0] ram_img [0:63];
    logic        load_ram = 1'b0;
    int          rom_wait = 0, ram_wait = 0, rom_cnt = 0, ram_cnt = 0, nw = 0, viol = 0;
    logic [14:0] wlog_addr [0:7];
    logic [15:0] wlog_data [0:7];

    hack_cpu_mc dut (
        .clk(clk), .reset_n(reset_n),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .pc(pc), .halted(halted)
    );

    hack_cpu_mc #(.HALT_DETECT(0)) u1 (
        .clk(clk), .reset_n(reset_n2),
        .rom_req(u1_rom_req), .rom_addr(u1_rom_addr), .rom_ack(u1_rom_ack), .rom_data(u1_rom_data),
        .ram_req(u1_ram_req), .ram_we(u1_ram_we), .ram_addr(u1_ram_addr), .ram_wdata(u1_ram_wdata),
        .ram_ack(u1_ram_ack), .ram_rdata(u1_ram_rdata), .pc(u1_pc), .halted(u1_halted)
    );

    // Memory models: ack after N cycles of request (N=0 -> same cycle)
    assign rom_ack      = rom_req && (rom_cnt >= rom_wait);
    assign rom_data     = rom[rom_addr[5:0]];
    assign ram_ack      = ram_req && (ram_cnt >= ram_wait);
    assign ram_rdata    = ram[ram_addr[5:0]];
    assign u1_rom_ack   = u1_rom_req;
    assign u1_rom_data  = rom[u1_rom_addr[5:0]];
    assign u1_ram_ack   = u1_ram_req;
    assign u1_ram_rdata = 16'h0000;

    // Wait counters, RAM storage and write log
    always @(posedge clk) begin
        rom_cnt <= (rom_req && !rom_ack) ? rom_cnt + 1 : 0;
        ram_cnt <= (ram_req && !ram_ack) ? ram_cnt + 1 : 0;
        if (load_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= ram_img[i];
            nw <= 0;
        end else if (ram_req && ram_ack && ram_we) begin
            ram[ram_addr[5:0]] <= ram_wdata;
            if (nw < 8) begin
                wlog_addr[nw] <= ram_addr;
                wlog_data[nw] <= ram_wdata;
            end
            nw <= nw + 1;
        end
    end

    // Request stability: once raised and not acked, req/addr/we/wdata must hold
    logic        h_rom = 1'b0, h_ram = 1'b0, h_we;
    logic [14:0] h_rom_addr, h_ram_addr;
    logic [15:0] h_wd;
    always @(posedge clk) begin
        if (load_ram) viol <= 0;
        else if (reset_n)
            viol <= viol
                + ((h_rom && (!rom_req || rom_addr !== h_rom_addr)) ? 1 : 0)
                + ((h_ram && (!ram_req || ram_addr !== h_ram_addr || ram_we !== h_we
                              || (h_we && ram_wdata !== h_wd))) ? 1 : 0);
        h_rom      <= reset_n && rom_req && !rom_ack;
        h_ram      <= reset_n && ram_req && !ram_ack;
        h_rom_addr <= rom_addr;
        h_ram_addr <= ram_addr;
        h_we       <= ram_we;
        h_wd       <= ram_wdata;
    end

    function automatic logic [15:0] c_ins(input logic a, input logic [5:0] comp,
                                          input logic [2:0] dest, input logic [2:0] jmp);
        return {3'b111, a, comp, dest, jmp};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            rom[i]     = 16'h0000;
            ram_img[i] = 16'h0000;
        end
    endtask

    // Hold reset, load RAM image, release on a falling edge
    task automatic start_run();
        reset_n = 1'b0;
        @(negedge clk);
        load_ram = 1'b1;
        @(negedge clk);
        load_ram = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Run until halted or budget; report first request cycle and first fetch of mark_addr
    task automatic run_prog(input int budget, input int mark_addr, output int t0, output int tm);
        t0 = -1;
        tm = -1;
        for (int c = 0; c < budget && !halted; c++) begin
            @(negedge clk);
            if (rom_req && t0 < 0) t0 = c;
            if (rom_req && int'(rom_addr) == mark_addr && tm < 0) tm = c;
        end
    endtask

    // Program 1: @5; D=A; @7; M=D; (END) @4; 0;JMP
    task automatic load_prog1();
        clear_mem();
        rom[0] = 16'd5;
        rom[1] = c_ins(1'b0, C_A, 3'b010, 3'b000);
        rom[2] = 16'd7;
        rom[3] = c_ins(1'b0, C_D, 3'b001, 3'b000);
        rom[4] = 16'd4;
        rom[5] = c_ins(1'b0, C_ZERO, 3'b000, 3'b111);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b want 0", rom_req); end
        checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (pc !== 15'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_zero_wait();
        int t0, tm;
        load_prog1();
        rom_wait = 0; ram_wait = 0;
        start_run();
        run_prog(200, 4, t0, tm);
        checks++; if (tm - t0 !== 11) begin errors++; $display("FAIL zw_cycles: got %0d want 11", tm - t0); end
        checks++; if (ram[7] !== 16'd5) begin errors++; $display("FAIL zw_ram7: got %0d want 5", ram[7]); end
        checks++; if (nw !== 1) begin errors++; $display("FAIL zw_writes: got %0d want 1", nw); end
        checks++; if (wlog_addr[0] !== 15'd7) begin errors++; $display("FAIL zw_waddr: got %0d want 7", wlog_addr[0]); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL zw_halted: got %b want 1", halted); end
        checks++; if (pc !== 15'd4) begin errors++; $display("FAIL zw_pc: got %0d want 4", pc); end
    endtask

    task automatic test_wait_states();
        int t0, tm;
        load_prog1();
        rom_wait = 3; ram_wait = 2;
        start_run();
        run_prog(400, 4, t0, tm);
        checks++; if (tm - t0 !== 25) begin errors++; $display("FAIL ws_cycles: got %0d want 25", tm - t0); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL ws_stable: got %0d violations want 0", viol); end
        checks++; if (ram[7] !== 16'd5) begin errors++; $display("FAIL ws_ram7: got %0d want 5", ram[7]); end
        checks++; if (nw !== 1) begin errors++; $display("FAIL ws_writes: got %0d want 1", nw); end
        checks++; if (halted !== 1'b1 || pc !== 15'd4) begin
            errors++; $display("FAIL ws_halt: got halted=%b pc=%0d want 1/4", halted, pc);
        end
        rom_wait = 0; ram_wait = 0;
    endtask

    // Each code against D<0, D=0, D>0; taken lands at 10, fall-through at 3
    task automatic test_jumps();
        logic [5:0] dsel [0:2];
        logic [7:0] mask [0:2];
        int t0, tm;
        logic [14:0] want;
        dsel[0] = C_NEG1; mask[0] = 8'hF0;
        dsel[1] = C_ZERO; mask[1] = 8'hCC;
        dsel[2] = C_ONE;  mask[2] = 8'hAA;
        for (int v = 0; v < 3; v++) begin
            for (int j = 0; j < 8; j++) begin
                clear_mem();
                rom[0]  = c_ins(1'b0, dsel[v], 3'b010, 3'b000);
                rom[1]  = 16'd10;
                rom[2]  = c_ins(1'b0, C_D, 3'b000, 3'(j));
                rom[3]  = 16'd3;
                rom[4]  = c_ins(1'b0, C_ZERO, 3'b000, 3'b111);
                rom[10] = 16'd10;
                rom[11] = c_ins(1'b0, C_ZERO, 3'b000, 3'b111);
                start_run();
                run_prog(200, 0, t0, tm);
                want = mask[v][j] ? 15'd10 : 15'd3;
                checks++;
                if (halted !== 1'b1 || pc !== want) begin
                    errors++;
                    $display("FAIL jump_d%0d_j%0d: got pc=%0d halted=%b want pc=%0d", v, j, pc, halted, want);
                end
            end
        end
    endtask

    task automatic test_am_write();
        int t0, tm;
        clear_mem();
        rom[0]  = 16'd3;
        rom[1]  = c_ins(1'b1, C_AP1, 3'b101, 3'b000);   // AM=M+1
        rom[2]  = c_ins(1'b0, C_A, 3'b010, 3'b000);     // D=A
        rom[3]  = 16'd20;
        rom[4]  = c_ins(1'b0, C_D, 3'b001, 3'b000);     // M=D
        rom[5]  = 16'd21;
        rom[6]  = c_ins(1'b1, C_A, 3'b100, 3'b111);     // A=M;JMP
        rom[30] = 16'd30;
        rom[31] = c_ins(1'b0, C_ZERO, 3'b000, 3'b111);
        ram_img[3]  = 16'd9;
        ram_img[21] = 16'd30;
        start_run();
        run_prog(300, 0, t0, tm);
        checks++; if (wlog_addr[0] !== 15'd3) begin errors++; $display("FAIL am_waddr: got %0d want 3", wlog_addr[0]); end
        checks++; if (wlog_data[0] !== 16'd10) begin errors++; $display("FAIL am_wdata: got %0d want 10", wlog_data[0]); end
        checks++; if (ram[20] !== 16'd10) begin errors++; $display("FAIL am_new_a: got %0d want 10", ram[20]); end
        checks++; if (nw !== 2) begin errors++; $display("FAIL am_writes: got %0d want 2", nw); end
        checks++; if (halted !== 1'b1 || pc !== 15'd30) begin
            errors++; $display("FAIL am_jmp_m: got pc=%0d halted=%b want 30/1", pc, halted);
        end
    endtask

    task automatic test_halt();
        int t0, tm, nreq, nloop;
        clear_mem();
        rom[0] = 16'd1;
        rom[1] = c_ins(1'b0, C_A, 3'b010, 3'b000);
        rom[2] = 16'd2;
        rom[3] = c_ins(1'b0, C_ZERO, 3'b000, 3'b111);
        start_run();
        run_prog(200, 0, t0, tm);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        nreq = 0;
        repeat (20) begin
            @(negedge clk);
            if (rom_req || ram_req) nreq++;
        end
        checks++; if (nreq !== 0) begin errors++; $display("FAIL halt_no_req: got %0d want 0", nreq); end
        checks++; if (pc !== 15'd2) begin errors++; $display("FAIL halt_pc: got %0d want 2", pc); end
        // Same program without halt detection keeps looping over 2/3
        reset_n2 = 1'b0;
        @(negedge clk);
        reset_n2 = 1'b1;
        nloop = 0;
        repeat (80) begin
            @(negedge clk);
            if (u1_rom_req && u1_rom_addr == 15'd2) nloop++;
        end
        checks++; if (u1_halted !== 1'b0) begin errors++; $display("FAIL nohalt_flag: got %b want 0", u1_halted); end
        checks++; if (nloop < 5) begin errors++; $display("FAIL nohalt_loops: got %0d want >=5", nloop); end
    endtask

    task automatic test_reset_mid_write();
        int t0, tm;
        bit seen;
        load_prog1();
        rom_wait = 0; ram_wait = 5;
        start_run();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (ram_req && ram_we) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_wr_reach: got no write request want one"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ram_req !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL rst_wr_drop: got req=%b we=%b want 0/0", ram_req, ram_we);
        end
        ram_wait = 0;
        repeat (2) @(negedge clk);
        checks++; if (nw !== 0) begin errors++; $display("FAIL rst_wr_abandon: got %0d writes want 0", nw); end
        reset_n = 1'b1;
        checks++; if (pc !== 15'd0) begin errors++; $display("FAIL rst_wr_pc: got %0d want 0", pc); end
        run_prog(200, 0, t0, tm);
        checks++; if (tm < 0) begin errors++; $display("FAIL rst_wr_refetch0: got none want fetch at 0"); end
        checks++; if (ram[7] !== 16'd5 || halted !== 1'b1) begin
            errors++; $display("FAIL rst_wr_rerun: got ram7=%0d halted=%b want 5/1", ram[7], halted);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jumps();
        test_am_write();
        test_halt();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
